// File: rtl/uart_tx_fifo.sv
// UART transmitter with valid/ready byte input, circular TX FIFO, runtime divisor and framing.
// Line-break generation is compiled in only when UART_TX_BREAK_EN is defined.
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic                          hs_clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          break_req,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
  localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK, S_MARK
`endif
  } state_t;

  state_t state, state_n;

  // Handshake: a byte is taken on every rising edge where tx_valid && tx_ready;
  // tx_ready is simply !full, so a pop in the same cycle never frees a slot early.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] rd_data;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_ready   = !full;
  assign push       = tx_valid && !full;
  assign fifo_level = wr_ptr - rd_ptr;
  assign rd_data    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge hs_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data[DATA_BITS-1:0];
  end

  always_ff @(posedge hs_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  logic [DIV_W-1:0]     div_eff, div_q, cnt;
  logic                 par_en_q, par_bit_q, stop2_q, stop_left;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 txd_q, busy_q, done_q;
  logic                 txd_n, busy_n, done_n;
  logic                 bit_end, shift, start_ok, brk_hold, finish, start_frame;

  assign div_eff = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
  assign bit_end = (cnt == '0);
  assign shift   = bit_end && ((state == S_START) || (state == S_DATA && bit_cnt != LAST_BIT));

`ifdef UART_TX_BREAK_EN
  logic mark_load;
  assign brk_hold = break_req;
`else
  logic unused_break;
  assign unused_break = break_req;
  assign brk_hold     = 1'b0;
`endif
  assign start_ok = !empty && !brk_hold;

  always_comb begin
    state_n     = state;
    txd_n       = txd_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    pop         = 1'b0;
    finish      = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_BREAK_EN
    mark_load   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_n = S_BREAK;
          txd_n   = 1'b0;
          busy_n  = 1'b1;
        end else
`endif
        if (start_ok) start_frame = 1'b1;
      end
      S_START: if (bit_end) begin
        state_n = S_DATA;
        txd_n   = shreg[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_cnt != LAST_BIT) begin
          txd_n = shreg[0];
        end else if (par_en_q) begin
          state_n = S_PARITY;
          txd_n   = par_bit_q;
        end else begin
          state_n = S_STOP;
          txd_n   = 1'b1;
        end
      end
      S_PARITY: if (bit_end) begin
        state_n = S_STOP;
        txd_n   = 1'b1;
      end
      S_STOP: if (bit_end && !stop_left) begin
        done_n = 1'b1;
        finish = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: if (!break_req) begin
        state_n   = S_MARK;
        txd_n     = 1'b1;
        mark_load = 1'b1;
      end
      S_MARK: if (bit_end) finish = 1'b1;
`endif
      default: state_n = S_IDLE;
    endcase
    // A frame end chains straight into the next start when a byte is waiting.
    if (finish) begin
      if (start_ok) begin
        start_frame = 1'b1;
      end else begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    end
    if (start_frame) begin
      state_n = S_START;
      pop     = 1'b1;
      txd_n   = 1'b0;
      busy_n  = 1'b1;
    end
  end

  always_ff @(posedge hs_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge hs_clk or negedge rst_n) begin
    if (!rst_n) begin
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt       <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_left <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      txd_q  <= txd_n;
      busy_q <= busy_n;
      done_q <= done_n;
      // Frame configuration is frozen here and held until the next frame start.
      if (pop) begin
        cnt       <= div_eff - DIV_ONE;
        div_q     <= div_eff;
        par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_q <= (^rd_data) ^ (parity_mode == 2'b10);
        stop2_q   <= stop2;
        shreg     <= rd_data;
        bit_cnt   <= '0;
`ifdef UART_TX_BREAK_EN
      end else if (mark_load) begin
        cnt   <= div_eff - DIV_ONE;
        div_q <= div_eff;
`endif
      end else begin
        cnt <= bit_end ? (div_q - DIV_ONE) : (cnt - DIV_ONE);
        if (shift) shreg <= shreg >> 1;
        if (state == S_DATA && bit_end)
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : (bit_cnt + BIT_ONE);
      end
      if (state != S_STOP && state_n == S_STOP)
        stop_left <= stop2_q;
      else if (state == S_STOP && bit_end)
        stop_left <= 1'b0;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign tx_done      = done_q;
  assign state_dbg    = state;
endmodule
